// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, STATUS bit indices, FSM states and count saturation for uart_tx_mmio
package uart_pkg;
  localparam logic [2:0] TXDATA_OFS = 3'd0;
  localparam logic [2:0] STATUS_OFS = 3'd4;
  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF = 2;
  localparam int ST_CNT = 3;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  function automatic logic [2:0] sat3(input int unsigned c);
    return c > 7 ? 3'd7 : 3'(c);
  endfunction
endpackage

// File: rtl/fifo_sync.sv
// fifo_sync: first-word-fall-through FIFO; ports clk, rst (sync active-low), push/din, pop/dout, full, empty, count; push while full is accepted when a pop happens in the same cycle
module fifo_sync #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [W-1:0]         din,
  input  logic                 pop,
  output logic [W-1:0]         dout,
  output logic                 full,
  output logic                 empty,
  output logic [$clog2(D):0]   count
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem [D];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(D);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: MMIO 8N1 UART transmitter; ports clk, rst (sync active-low), addr/wr_data/st/ld bus, hit and rd_data (combinational), tx (registered serial out)
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] BASE_ADDR = 32'h0000_FF00,
  parameter int               CLK_DIV = 868,
  parameter int               FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             st,
  input  logic             ld,
  output logic             hit,
  output logic [WIDTH-1:0] rd_data,
  output logic             tx
);
  localparam int BW = $clog2(CLK_DIV);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state;
  logic [BW-1:0] baud;
  logic [2:0] idx;
  logic [7:0] shift, head;
  logic [CW-1:0] count;
  logic [5:0] status;
  logic ovf, full, empty, bit_end, pop, push, sel_tx, sel_st, unused_ok;
  assign hit = addr[WIDTH-1:3] == BASE_ADDR[WIDTH-1:3];
  assign sel_tx = {addr[2], 2'b00} == TXDATA_OFS;
  assign sel_st = {addr[2], 2'b00} == STATUS_OFS;
  assign push = st && hit && sel_tx;
  assign bit_end = baud == BW'(CLK_DIV - 1);
  assign pop = !empty && (state == IDLE || (state == STOP && bit_end));
  assign status = {sat3(32'(count)), ovf, full, state != IDLE || !empty};
  assign rd_data = ld && hit && sel_st ? WIDTH'(status) : '0;
  assign unused_ok = ^{addr[1:0], wr_data[WIDTH-1:8]};
  fifo_sync #(.W(8), .D(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(wr_data[7:0]), .pop(pop),
    .dout(head), .full(full), .empty(empty), .count(count)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      tx <= 1'b1;
      baud <= '0;
      idx <= '0;
      shift <= '0;
      ovf <= 1'b0;
    end else begin
      if (push && full && !pop) ovf <= 1'b1;
      else if (st && hit && sel_st && wr_data[ST_OVF]) ovf <= 1'b0;
      baud <= state == IDLE || bit_end ? '0 : baud + 1'b1;
      if (pop) begin
        shift <= head;
        idx <= '0;
        state <= START;
        tx <= 1'b0;
      end else if (bit_end)
        case (state)
          IDLE: ;
          START: begin
            state <= DATA;
            tx <= shift[0];
          end
          DATA: if (idx == 3'd7) begin
            state <= STOP;
            tx <= 1'b1;
          end else begin
            shift <= shift >> 1;
            idx <= idx + 3'd1;
            tx <= shift[1];
          end
          STOP: begin
            state <= IDLE;
            tx <= 1'b1;
          end
        endcase
    end
endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the RV32I processor data bus, beside the data memory. Decodes processor stores/loads to a small register window, buffers bytes in a FIFO, and serialises them as 8N1 frames on a single `tx` pin. This gives FPGA builds a console output beyond the 8 LEDs. The top level ORs `rd_data` with the memory read data; `hit` qualifies it.

## Interface
- `WIDTH`, 32: bus data/address width.
- `BASE_ADDR`, 32'h0000_FF00: register window base; window spans BASE_ADDR..BASE_ADDR+7.
- `CLK_DIV`, 868: clock cycles per serial bit (100 MHz / 115200). Must be ≥ 2.
- `FIFO_DEPTH`, 4: TX FIFO entries. Power of two, ≥ 2.

- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `addr` in WIDTH: processor address (AddrToMemSys).
- `wr_data` in WIDTH: processor store data (DataFromMSToMemSys).
- `st` in 1: store strobe (weToMemSys).
- `ld` in 1: load strobe (reToMemSys).
- `hit` out 1: combinational, 1 when `addr[WIDTH-1:3] == BASE_ADDR[WIDTH-1:3]`.
- `rd_data` out WIDTH: combinational read data; 0 unless `ld && hit`.
- `tx` out 1: serial output, idle high.

## Operation
- Registers are word-aligned. `addr[1:0]` is ignored.
  - Offset 0 is TXDATA (write-only; reads return 0).
  - Offset 4 is STATUS.
- STATUS bits:
  - [0] busy: FSM not IDLE, or FIFO non-empty.
  - [1] full: count == FIFO_DEPTH.
  - [2] overflow: sticky.
  - [5:3] count: FIFO occupancy, saturating width 3.
  - [31:6] are 0.
- Store to TXDATA: pushes `wr_data[7:0]` if not full. If full, the byte is dropped and overflow is set.
- Store to STATUS with `wr_data[2]=1`: clears overflow. All other bits are ignored.
- Overflow set and clear in the same cycle cannot occur, because they target different offsets.
- Push while full in the same cycle as an FSM pop: accepted, and count is unchanged. `full` is evaluated after the pop.
- FSM states and transitions:
  - IDLE: `tx=1`. If FIFO non-empty: pop into an 8-bit shift register, clear the baud counter and bit index, go to START.
  - START: `tx=0` for CLK_DIV cycles, then go to DATA.
  - DATA: `tx=shift[0]`, LSB first. Every CLK_DIV cycles, shift right and increment the bit index. After bit 7 completes, go to STOP.
  - STOP: `tx=1` for CLK_DIV cycles. Then, if FIFO non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter: counts 0..CLK_DIV-1, and the bit ends when it reaches CLK_DIV-1. It is sized `$clog2(CLK_DIV)`.
- `tx` is registered (glitch-free).

## Timing
- Reset values (asserted at an edge, effective after that edge):
  - `tx=1`, FSM=IDLE, FIFO empty, overflow=0.
  - `rd_data=0` and `hit` stay combinational.
- Reset mid-frame: the frame is truncated and `tx` is 1 after the reset edge. The FIFO contents are discarded.
- Store sampled at edge E: the FIFO entry is visible at E. The IDLE pop happens at E+1, and `tx` falls after E+1.
- Frame length: exactly 10·CLK_DIV cycles, from `tx` falling edge to the end of the stop bit.
- Back-to-back bytes: the next start bit begins the cycle immediately after the stop bit ends.
- STATUS read reflects register state before the current edge. There is no load side effect.

## Structure
- Package `uart_pkg`:
  - register offsets (TXDATA=0, STATUS=4);
  - STATUS bit indices;
  - FSM state enum {IDLE, START, DATA, STOP}, 2-bit encoding.
- Sub-module `fifo_sync`:
  - parameterised width/depth;
  - push/pop/full/empty/count;
  - simultaneous push+pop when full is allowed.
- Top of block: address decode, STATUS register, baud counter and FSM.
- Integration: the top level drives `Mdelay=0`, since the block never stalls the bus.

## Test plan
- Reset then idle (run with CLK_DIV=4): hold `rst=0` 3 cycles and release → `tx=1`, STATUS read = 0x0, `hit=0` for `addr=0x0`.
- Single byte: store 0x55 to 0xFF00 → `tx` low 4 cycles starting 2 edges later, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles. STATUS.busy=1 during the frame and 0 after.
- Back-to-back: store 0x00 then 0xFF on consecutive cycles → two 40-cycle frames with no gap. Count reads 1 during the first frame.
- Overflow: with DEPTH=4, store 6 bytes in 6 consecutive cycles → first pop at the second edge, 4 in FIFO; the 6th is dropped and STATUS = 0x27 (count 4, full, overflow, busy). Store 0x4 to 0xFF04 → overflow cleared. Only the first 5 bytes appear on `tx`.
- Push+pop while full: fill the FIFO, then store on the exact STOP→START pop cycle → byte accepted, no overflow, count stays 4.
- Reset mid-frame: assert `rst=0` during DATA of byte 0xA5 → `tx=1` after the edge, STATUS=0, and no further frame follows.
